icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  AHB-Lite master-side line refill sequencer for the I-cache. On a cache miss it
//  issues one WRAP4 read burst, critical word first, wrapping within the 16-byte
//  line. It writes each returned word into the line array and reports completion.
//  It sits between the cache miss logic and the AHB transfer handler/bus.
// PARAMETERS
//  ADDR_W   32  address width; line = 4 words x 32 bit, 16-byte aligned
//  CRIT_1ST  1  1: burst starts at miss word; 0: burst starts at line offset 0
// PORTS
//  clk              in   1       clock, all state on posedge
//  rst              in   1       synchronous reset, active-high
//  miss_req         in   1       refill request, sampled only in IDLE
//  miss_addr        in   ADDR_W  missing byte address, sampled with miss_req
//  busy             out  1       refill in progress (request not accepted)
//  haddr            out  ADDR_W  AHB address, registered
//  htrans           out  2       IDLE=00 NONSEQ=10 SEQ=11, registered
//  hburst           out  3       WRAP4=010 during burst, else SINGLE=000
//  hsize            out  3       constant 010 (word)
//  hwrite           out  1       constant 0
//  hready           in   1       AHB transfer-done / stall
//  hresp            in   1       AHB response, 1=ERROR
//  hrdata           in   32      AHB read data
//  refill_we        out  1       line-array write strobe (comb: data phase && hready)
//  refill_word_idx  out  2       word index within line for refill_we
//  refill_data      out  32      = hrdata
//  refill_done      out  1       1-cycle pulse after last data beat
//  refill_err       out  1       1-cycle pulse with refill_done if burst errored
// BEHAVIOUR
//  - Reset: state IDLE, htrans=00, hburst=000, haddr=0, busy=0, refill_done=0,
//    refill_err=0, counters 0; reset mid-burst abandons it (htrans=00 next cycle),
//    no refill_done is generated for the abandoned burst.
//  - States: IDLE -> ADDR (NONSEQ beat) -> BURST (SEQ beats) -> DRAIN (last data) -> IDLE.
//  - IDLE & miss_req: latch base=miss_addr&~'hF, off0=CRIT_1ST?miss_addr[3:2]:0;
//    next cycle htrans=NONSEQ, haddr=base|off0<<2, busy=1.
//  - Address beat n (n=0..3): word index = (off0+n) mod 4 (2-bit wrap).
//    Advance to beat n+1 only on a cycle with hready=1; hold haddr/htrans otherwise.
//  - After beat 3 is accepted: htrans=IDLE, hburst=SINGLE; the data phase for beat 3 remains.
//  - Data phase of beat n = the cycle(s) after its address was accepted, ending on hready=1.
//    refill_we=1 with refill_word_idx=(off0+n) mod 4 on that hready cycle only.
//  - refill_done pulses the cycle after beat 3 data; busy=0 the same cycle. A miss_req
//    in that cycle is accepted (back-to-back, NONSEQ the following cycle).
//  - miss_req while busy=1 is ignored; the requester holds it until busy falls.
//  - Exactly 4 refill_we pulses per error-free burst; each word index appears once.
// CONFIGURATION
//  REFILL_ERR_ABORT_EN defined: on hresp=1 in any data phase, drive htrans=IDLE next
//   cycle, suppress refill_we for that beat and all later beats, wait for hready=1,
//   then pulse refill_done and refill_err together; return to IDLE.
//  Not defined: hresp is ignored, the burst always completes 4 beats, refill_err=0.
// TESTING
//  1 miss_addr=0x1008, hready=1: NONSEQ 0x1008, SEQ 0x100C,0x1000,0x1004;
//    refill_we idx 2,3,0,1; refill_done 6 cycles after miss_req.
//  2 same burst, hready=0 for 2 cycles at beat 1: haddr/htrans held, no refill_we
//    during stall, 4 writes total, done delayed by 2 cycles.
//  3 CRIT_1ST=0, miss_addr=0x200C: addresses 0x2000..0x200C in order, idx 0,1,2,3.
//  4 miss_req held through done: second NONSEQ the cycle after refill_done.
//  5 rst=1 during beat 2: htrans=00, busy=0 next cycle, no refill_done.
//  6 REFILL_ERR_ABORT_EN, hresp=1 on beat 1 data: htrans=00 next cycle, 1 write
//    only (idx of beat 0), refill_done=refill_err=1 same cycle.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one AHB-Lite WRAP4 read burst per miss, critical word first.
// Optional error abort is built when REFILL_ERR_ABORT_EN is defined.
module icache_refill_ctrl #(
    parameter int ADDR_W   = 32,
    parameter bit CRIT_1ST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic              hwrite,
    input  logic              hready,
    input  logic              hresp,
    input  logic [31:0]       hrdata,
    output logic              refill_we,
    output logic [1:0]        refill_word_idx,
    output logic [31:0]       refill_data,
    output logic              refill_done,
    output logic              refill_err
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_WRAP4  = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:4]   base_q;
    logic [1:0]          off0_q;
    logic [1:0]          abeat_q;
    logic [1:0]          dbeat_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic [1:0]          htrans_q;
    logic [2:0]          hburst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                abort_q;

    logic [1:0]          off0_d;
    logic [1:0]          widx_next_d;
    logic                dphase_live;
    logic                err_hit;

    assign off0_d      = CRIT_1ST ? miss_addr[3:2] : 2'b00;
    assign widx_next_d = off0_q + abeat_q + 2'd1;

    // A data phase runs alongside every address beat after the first, and in DRAIN.
    assign dphase_live = ((state_q == S_BURST) || (state_q == S_DRAIN)) && !abort_q;

`ifdef REFILL_ERR_ABORT_EN
    assign err_hit = dphase_live && hresp;
`else
    logic unused_hresp;
    assign unused_hresp = hresp;
    assign err_hit      = 1'b0;
`endif

    assign refill_we       = dphase_live && hready && !err_hit;
    assign refill_word_idx = off0_q + dbeat_q;
    assign refill_data     = hrdata;

    assign busy        = busy_q;
    assign haddr       = haddr_q;
    assign htrans      = htrans_q;
    assign hburst      = hburst_q;
    assign hsize       = 3'b010;
    assign hwrite      = 1'b0;
    assign refill_done = done_q;
    assign refill_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            off0_q   <= '0;
            abeat_q  <= '0;
            dbeat_q  <= '0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hburst_q <= HB_SINGLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (miss_req) begin
                        base_q   <= miss_addr[ADDR_W-1:4];
                        off0_q   <= off0_d;
                        haddr_q  <= {miss_addr[ADDR_W-1:4], off0_d, 2'b00};
                        htrans_q <= HT_NONSEQ;
                        hburst_q <= HB_WRAP4;
                        busy_q   <= 1'b1;
                        abeat_q  <= 2'd0;
                        dbeat_q  <= 2'd0;
                        abort_q  <= 1'b0;
                        state_q  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        abeat_q  <= 2'd1;
                        dbeat_q  <= 2'd0;
                        haddr_q  <= {base_q, widx_next_d, 2'b00};
                        htrans_q <= HT_SEQ;
                        state_q  <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (err_hit) begin
                        htrans_q <= HT_IDLE;
                        hburst_q <= HB_SINGLE;
                        if (hready) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            abort_q <= 1'b1;
                            state_q <= S_DRAIN;
                        end
                    end else if (hready) begin
                        dbeat_q <= abeat_q;
                        if (abeat_q == 2'd3) begin
                            htrans_q <= HT_IDLE;
                            hburst_q <= HB_SINGLE;
                            state_q  <= S_DRAIN;
                        end else begin
                            abeat_q <= abeat_q + 2'd1;
                            haddr_q <= {base_q, widx_next_d, 2'b00};
                        end
                    end
                end
                S_DRAIN: begin
                    // Aborted bursts wait here for the error response to complete.
                    if (hready) begin
                        done_q  <= 1'b1;
                        err_q   <= abort_q || err_hit;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (err_hit) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed bursts plus random traffic against a transaction-level AHB model.
module tb_icache_refill_ctrl;

    localparam bit TB_CRIT = 1'b1;
`ifdef REFILL_ERR_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        busy;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;
    logic        refill_we;
    logic [1:0]  refill_word_idx;
    logic [31:0] refill_data;
    logic        refill_done;
    logic        refill_err;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.ADDR_W(32), .CRIT_1ST(TB_CRIT)) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .haddr(haddr), .htrans(htrans), .hburst(hburst),
        .hsize(hsize), .hwrite(hwrite), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .refill_we(refill_we), .refill_word_idx(refill_word_idx),
        .refill_data(refill_data), .refill_done(refill_done), .refill_err(refill_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expectations for the current cycle, derived from bus-level rules.
    bit          m_busy, m_done, m_err, m_act, m_pend, m_errwait;
    int          m_n, m_pn;
    logic [31:0] m_base;
    int          m_off0;
    int          dut_wr;
    logic [3:0]  dut_mask;

    function automatic logic [31:0] beat_addr(input int n);
        return m_base + 32'(((m_off0 + n) % 4) * 4);
    endfunction

    task automatic model_step();
        bit err_now, exp_we, nd, ne;
        chk("busy", busy, m_busy);
        chk("done", refill_done, m_done);
        chk("err", refill_err, m_err);
        chk("hsize", hsize, 3'b010);
        chk("hwrite", hwrite, 1'b0);
        if (m_act) begin
            chk("htrans", htrans, (m_n == 0) ? 2'b10 : 2'b11);
            chk("haddr", haddr, beat_addr(m_n));
            chk("hburst", hburst, 3'b010);
        end else begin
            chk("htrans_idle", htrans, 2'b00);
            chk("hburst_idle", hburst, 3'b000);
        end
        err_now = ABORT && m_pend && hresp;
        exp_we  = m_pend && hready && !err_now;
        chk("we", refill_we, exp_we);
        if (exp_we && refill_we) begin
            chk("widx", refill_word_idx, 32'((m_off0 + m_pn) % 4));
            chk("wdata", refill_data, hrdata);
        end
        if (refill_we) begin
            dut_wr++;
            dut_mask[refill_word_idx] = 1'b1;
        end
        if (refill_done && !refill_err && m_done) begin
            chk("wr_count", dut_wr, 4);
            chk("wr_mask", dut_mask, 4'hF);
        end
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_act = 0; m_pend = 0; m_errwait = 0;
        end else begin
            nd = 0; ne = 0;
            if (err_now) begin
                m_act = 0; m_pend = 0;
                if (hready) begin nd = 1; ne = 1; end
                else m_errwait = 1;
            end else if (m_errwait) begin
                if (hready) begin nd = 1; ne = 1; m_errwait = 0; end
            end else if (hready) begin
                if (m_pend && m_pn == 3) nd = 1;
                m_pend = m_act;
                m_pn   = m_n;
                if (m_act) begin
                    m_n++;
                    if (m_n == 4) m_act = 0;
                end
            end
            if (!m_busy && miss_req) begin
                m_base = miss_addr & ~32'hF;
                m_off0 = TB_CRIT ? int'(miss_addr[3:2]) : 0;
                m_n = 0; m_act = 1; m_busy = 1; m_pend = 0; m_errwait = 0;
                dut_wr = 0; dut_mask = 4'h0;
            end else if (nd) begin
                m_busy = 0;
            end
            m_done = nd;
            m_err  = ne;
        end
    endtask

    task automatic cycle(input bit r, input bit mreq, input logic [31:0] maddr,
                         input bit rdy, input bit resp);
        @(posedge clk);
        #1;
        rst = r; miss_req = mreq; miss_addr = maddr; hready = rdy; hresp = resp;
        hrdata = $urandom;
        @(negedge clk);
        model_step();
    endtask

    int lat;

    initial begin
        m_busy = 0; m_done = 0; m_err = 0; m_act = 0; m_pend = 0; m_errwait = 0;
        m_n = 0; m_pn = 0; m_base = '0; m_off0 = 0; dut_wr = 0; dut_mask = '0;

        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        chk("rst_haddr", haddr, 32'h0);
        cycle(0, 0, 0, 1, 0);

        // Burst with no wait states: done six cycles after the request.
        cycle(0, 1, 32'h1008, 1, 0);
        lat = 99;
        for (int i = 1; i <= 20 && lat == 99; i++) begin
            cycle(0, 0, 0, 1, 0);
            if (refill_done) lat = i;
        end
        chk("t1_latency", lat, 6);
        cycle(0, 0, 0, 1, 0);

        // Two wait states at beat 1.
        cycle(0, 1, 32'h1008, 1, 0);
        lat = 99;
        for (int i = 1; i <= 20 && lat == 99; i++) begin
            cycle(0, 0, 0, (i == 2 || i == 3) ? 1'b0 : 1'b1, 0);
            if (refill_done) lat = i;
        end
        chk("t2_latency", lat, 8);
        cycle(0, 0, 0, 1, 0);

        // Request held through done: back-to-back bursts.
        for (int i = 0; i < 14; i++) cycle(0, 1, 32'h3004, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);

        // Reset during beat 2 abandons the burst.
        cycle(0, 1, 32'h4000, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        chk("t5_rst_busy_pre", busy, 1'b1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);

`ifdef REFILL_ERR_ABORT_EN
        // Error on beat 1 data: one write only, then done with error.
        cycle(0, 1, 32'h1008, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        chk("t6_htrans", htrans, 2'b00);
        cycle(0, 0, 0, 1, 0);
        chk("t6_done", refill_done, 1'b1);
        chk("t6_err", refill_err, 1'b1);
        chk("t6_writes", dut_wr, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 250) == 0,
                  ($urandom % 3) == 0,
                  $urandom,
                  ($urandom % 4) != 0,
                  ABORT ? (($urandom % 20) == 0) : ($urandom % 2 == 1));
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
